// File: rtl/noc_pkg.sv
// noc_pkg: shared port/direction encodings and XY routing for the bufferless router
package noc_pkg;
    localparam int ADDR_W = 6;
    localparam int ROW_MSB = 5;
    localparam int ROW_LSB = 3;
    localparam int COL_MSB = 2;
    localparam int COL_LSB = 0;
    localparam logic [1:0] P_N = 2'd0;
    localparam logic [1:0] P_S = 2'd1;
    localparam logic [1:0] P_E = 2'd2;
    localparam logic [1:0] P_W = 2'd3;
    localparam logic [4:0] DIR_E = 5'b00001;
    localparam logic [4:0] DIR_W = 5'b00010;
    localparam logic [4:0] DIR_N = 5'b00100;
    localparam logic [4:0] DIR_S = 5'b01000;
    localparam logic [4:0] DIR_LOCAL = 5'b10000;
    typedef enum logic [1:0] {IDLE, WAIT, STARVED} state_t;
    function automatic logic [4:0] xy_route(input logic [ADDR_W-1:0] addr, input logic [2:0] row, input logic [2:0] col);
        return addr[COL_MSB:COL_LSB] > col ? DIR_E :
               addr[COL_MSB:COL_LSB] < col ? DIR_W :
               addr[ROW_MSB:ROW_LSB] > row ? DIR_N :
               addr[ROW_MSB:ROW_LSB] < row ? DIR_S : DIR_LOCAL;
    endfunction
endpackage

// File: rtl/inj_fifo.sv
// inj_fifo: small power-of-two FIFO buffering locally generated flit addresses
module inj_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign ready = count < CW'(DEPTH);
    assign push_ok = push & ready;
    assign pop_ok = pop & (count != '0);
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/inject_scheduler.sv
// inject_scheduler: grants idle router slots round-robin to queued local flits,
// loops back self-addressed flits and flags prolonged injection starvation.
module inject_scheduler
    import noc_pkg::*;
#(
    parameter logic [2:0] ROW = 3'd4,
    parameter logic [2:0] COL = 3'd4,
    parameter int DEPTH = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [ADDR_W-1:0] src_addr,
    output logic              src_ready,
    input  logic [3:0]        in_valid,
    output logic [3:0]        inj_valid,
    output logic [ADDR_W-1:0] inj_addr,
    output logic [4:0]        inj_dir,
    output logic              loop_valid,
    output logic              starve,
    output logic [2:0]        fifo_count
);
    localparam int CW = $clog2(DEPTH+1);
    logic [ADDR_W-1:0] head;
    logic [CW-1:0] count, count_next;
    logic [4:0] route;
    logic is_local, free_found, pop;
    logic [1:0] rr, gnt;
    logic [3:0] blk, blk_next;
    state_t state;
    inj_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(src_valid), .pop(pop), .din(src_addr),
        .head(head), .count(count), .ready(src_ready)
    );
    assign route = xy_route(head, ROW, COL);
    assign is_local = route == DIR_LOCAL;
    // Descending scan so the last hit is the first free slot at or after rr.
    always_comb begin
        gnt = rr;
        free_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!in_valid[rr + 2'(i)]) begin
                gnt = rr + 2'(i);
                free_found = 1'b1;
            end
        end
    end
    assign pop = (count != '0) && (is_local || free_found);
    assign count_next = count + CW'(src_valid & src_ready) - CW'(pop);
    assign blk_next = (count != '0 && !pop) ? (blk == 4'(STARVE_LIMIT) ? blk : blk + 4'd1) : 4'd0;
    assign starve = state == STARVED;
    assign fifo_count = 3'(count);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= P_N;
            blk <= '0;
            state <= IDLE;
            inj_valid <= '0;
            inj_addr <= '0;
            inj_dir <= '0;
            loop_valid <= 1'b0;
        end else begin
            rr <= (pop && !is_local) ? gnt + 2'd1 : rr;
            inj_valid <= (pop && !is_local) ? 4'b0001 << gnt : 4'b0000;
            loop_valid <= pop && is_local;
            if (pop) begin
                inj_addr <= head;
                inj_dir <= route;
            end
            blk <= blk_next;
            state <= count_next == '0 ? IDLE : blk_next == 4'(STARVE_LIMIT) ? STARVED : WAIT;
        end
    end
endmodule
